exec_multicycle_ctrl: RTL and testbench
=======================================

// Module: exec_multicycle_ctrl
// PURPOSE
//  Execute-stage sequencer for one issue lane's multicycle FPU ops (FMUL/FDIV/FSQRT/FCVT).
//  Launches the op, counts its fixed latency and drives stall_e into the hazard unit
//  (one instance per lane: StallE1/StallE2). Holds the finished result while the pipe stays stalled.
//  Sits between the E-stage pipeline register and the FPU datapath; feeds the hazard unit and the W mux.
// PARAMETERS
//  LAT_FMUL   2   cycles from launch to result for op 2'b00
//  LAT_FDIV   10  cycles for op 2'b01
//  LAT_FSQRT  12  cycles for op 2'b10
//  LAT_FCVT   1   cycles for op 2'b11
//  CNT_W      4   latency counter width; every LAT_* < 2**CNT_W; a LAT of 0 is treated as 1
//  DATA_W     32  result width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rstn         in   1       asynchronous active-low reset
//  start        in   1       valid multicycle op present in E stage this cycle
//  op           in   2       op select, sampled at launch
//  rd           in   6       destination register (int/float unified index), sampled at launch
//  flush_e      in   1       kill the E-stage op (branch fail / FlashE)
//  stall_other  in   1       pipe held by another source (lane stall, lwStall)
//  result_in    in   DATA_W  FPU datapath output, valid on the done cycle
//  stall_e      out  1       request pipe stall (to hazard unit)
//  unit_en      out  1       FPU pipeline clock enable
//  done         out  1       result valid on result_out / rd_done
//  rd_done      out  6       destination of the completing op
//  result_out   out  DATA_W  completed result
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, op/rd/result regs 0; all outputs 0 while rstn low; reset wins over all.
//  States IDLE, BUSY, DONE. launch = IDLE & start & ~flush_e; L = max(1, LAT_op).
//  IDLE: launch with L==1 -> done=1 same cycle, result_out=result_in, rd_done=rd, stall_e=0;
//    next state DONE if stall_other, else IDLE. Launch with L>1 -> stall_e=1 (combinational),
//    cnt<=L-2, capture op/rd, go BUSY.
//  BUSY: cnt!=0 -> stall_e=1, cnt<=cnt-1. cnt==0 -> done cycle: stall_e=0, done=1,
//    result_out=result_in, rd_done=latched rd, result_in captured to hold reg;
//    next state DONE if stall_other, else IDLE.
//  Net timing: launch in cycle 0 -> stall_e high cycles 0..L-2, done in cycle L-1.
//  DONE: done=1, result_out=hold reg, stall_e=0, start ignored (same instr still in E);
//    exit to IDLE in the first cycle with stall_other=0 (done still 1 in that cycle).
//  start while BUSY/DONE is ignored; never relaunch the held instruction.
//  flush_e: highest priority after reset; in any state -> next IDLE, stall_e=0 and done=0
//    combinationally that cycle, cnt cleared; flush_e with start in IDLE -> no launch.
//  unit_en = launch | (state==BUSY); FPU not advanced in IDLE/DONE.
//  rd==0 ops still sequence and assert done; the consumer ignores writes to 0.
//  cnt never wraps: it is loaded only at launch and decremented only while nonzero.
// TESTING
//  FDIV (L=10), start at c0, stall_other=0 -> stall_e c0..c8, done c9, result_out=result_in(c9), c10 IDLE.
//  FCVT (L=1), rd=5 -> done=1, rd_done=5 in c0, stall_e never high, busy stays 0.
//  FSQRT launch, flush_e at c3 -> stall_e=0 in c3, no done, IDLE c4; new FMUL at c4 -> done c5.
//  FMUL done with stall_other=1 for 3 cycles, result 0x3F800000 -> done held 4 cycles, value
//    constant while result_in changes, start held high not relaunched.
//  rstn low at c4 of FDIV -> all outputs 0 immediately; rstn high -> IDLE, next start launches cleanly.
//  flush_e and start together in IDLE -> no launch, stall_e=0, unit_en=0.

Source files
------------

// File: rtl/exec_multicycle_ctrl.sv
// Execute-stage sequencer for one lane's multicycle FPU ops: launches the op, counts its
// fixed latency while stalling the pipe, and holds the finished result until the pipe moves on.
module exec_multicycle_ctrl #(
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FDIV  = 10,
  parameter int LAT_FSQRT = 12,
  parameter int LAT_FCVT  = 1,
  parameter int CNT_W     = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [5:0]        rd,
  input  logic              flush_e,
  input  logic              stall_other,
  input  logic [DATA_W-1:0] result_in,
  output logic              stall_e,
  output logic              unit_en,
  output logic              done,
  output logic [5:0]        rd_done,
  output logic [DATA_W-1:0] result_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // A zero latency behaves like a single-cycle op.
  localparam logic [CNT_W-1:0] LatMul  = (LAT_FMUL  < 1) ? CNT_W'(1) : CNT_W'(LAT_FMUL);
  localparam logic [CNT_W-1:0] LatDiv  = (LAT_FDIV  < 1) ? CNT_W'(1) : CNT_W'(LAT_FDIV);
  localparam logic [CNT_W-1:0] LatSqrt = (LAT_FSQRT < 1) ? CNT_W'(1) : CNT_W'(LAT_FSQRT);
  localparam logic [CNT_W-1:0] LatCvt  = (LAT_FCVT  < 1) ? CNT_W'(1) : CNT_W'(LAT_FCVT);

  state_t              state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic [1:0]          opReg, opNext;
  logic [5:0]          rdReg, rdNext;
  logic [DATA_W-1:0]   holdReg, holdNext;
  logic [CNT_W-1:0]    latSel;
  logic                launch;
  logic                stallC, doneC;
  logic [5:0]          rdDoneC;
  logic [DATA_W-1:0]   resC;

  always_comb begin
    case (op)
      2'b00:   latSel = LatMul;
      2'b01:   latSel = LatDiv;
      2'b10:   latSel = LatSqrt;
      default: latSel = LatCvt;
    endcase
  end

  assign launch = (state == IDLE) && start && !flush_e;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    opNext    = opReg;
    rdNext    = rdReg;
    holdNext  = holdReg;
    stallC    = 1'b0;
    doneC     = 1'b0;
    rdDoneC   = '0;
    resC      = '0;
    if (flush_e) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opNext = op;
            rdNext = rd;
            if (latSel == CNT_W'(1)) begin
              doneC     = 1'b1;
              resC      = result_in;
              rdDoneC   = rd;
              holdNext  = result_in;
              stateNext = stall_other ? DONE : IDLE;
            end else begin
              stallC    = 1'b1;
              cntNext   = latSel - CNT_W'(2);
              stateNext = BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            stallC  = 1'b1;
            cntNext = cnt - CNT_W'(1);
          end else begin
            doneC     = 1'b1;
            resC      = result_in;
            rdDoneC   = rdReg;
            holdNext  = result_in;
            stateNext = stall_other ? DONE : IDLE;
          end
        end
        DONE: begin
          // Same instruction still sits in E; start is not a new op here.
          doneC   = 1'b1;
          resC    = holdReg;
          rdDoneC = rdReg;
          if (!stall_other) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      opReg   <= '0;
      rdReg   <= '0;
      holdReg <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      opReg   <= opNext;
      rdReg   <= rdNext;
      holdReg <= holdNext;
    end
  end

  // Outputs forced low while reset is asserted, even though start may still be high.
  assign stall_e    = rstn && stallC;
  assign done       = rstn && doneC;
  assign rd_done    = rstn ? rdDoneC : 6'd0;
  assign result_out = rstn ? resC : '0;
  assign unit_en    = rstn && (launch || (state == BUSY));
  assign busy       = rstn && (state != IDLE);

endmodule

// File: tb/tb_exec_multicycle_ctrl.sv
// Bench for exec_multicycle_ctrl: directed scenarios then random traffic, checked against a
// transaction-level model that tracks each op by its age since launch.
module tb_exec_multicycle_ctrl;

  logic        clk, rstn, start, flush_e, stall_other;
  logic [1:0]  op;
  logic [5:0]  rd;
  logic [31:0] result_in;
  logic        stall_e, unit_en, done, busy;
  logic [5:0]  rd_done;
  logic [31:0] result_out;

  int tests = 0;
  int fails = 0;

  // Reference model state: one op in flight (aged from launch) or one result held.
  bit          mInflight, mHeld;
  int          mAge, mL;
  logic [5:0]  mRd;
  logic [31:0] mHold;
  logic        eStall, eDone, eUnit, eBusy;
  logic [5:0]  eRd;
  logic [31:0] eRes;

  exec_multicycle_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .rd(rd), .flush_e(flush_e),
    .stall_other(stall_other), .result_in(result_in), .stall_e(stall_e), .unit_en(unit_en),
    .done(done), .rd_done(rd_done), .result_out(result_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int latOf(input logic [1:0] o);
    case (o)
      2'b00:   return 2;
      2'b01:   return 10;
      2'b10:   return 12;
      default: return 1;
    endcase
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelEval();
    bit launch;
    eStall = 0; eDone = 0; eUnit = 0; eBusy = 0; eRd = '0; eRes = '0;
    if (rstn) begin
      launch = !mInflight && !mHeld && start && !flush_e;
      eBusy  = mInflight || mHeld;
      eUnit  = launch || mInflight;
      if (flush_e) begin
        eStall = 0;
      end else if (mHeld) begin
        eDone = 1; eRd = mRd; eRes = mHold;
      end else if (mInflight) begin
        if (mAge < mL - 1) eStall = 1;
        else begin eDone = 1; eRd = mRd; eRes = result_in; end
      end else if (start) begin
        if (latOf(op) == 1) begin eDone = 1; eRd = rd; eRes = result_in; end
        else eStall = 1;
      end
    end
  endtask

  task automatic modelCommit();
    if (!rstn || flush_e) begin
      mInflight = 0; mHeld = 0; mAge = 0;
      if (!rstn) begin mRd = '0; mHold = '0; end
    end else if (mHeld) begin
      if (!stall_other) mHeld = 0;
    end else if (mInflight) begin
      if (mAge < mL - 1) mAge++;
      else begin
        mInflight = 0;
        if (stall_other) begin mHeld = 1; mHold = result_in; end
      end
    end else if (start) begin
      mRd = rd;
      if (latOf(op) == 1) begin
        if (stall_other) begin mHeld = 1; mHold = result_in; end
      end else begin
        mInflight = 1; mAge = 1; mL = latOf(op);
      end
    end
  endtask

  task automatic settle();
    #3;
    modelEval();
    check1("stall_e", {31'd0, stall_e}, {31'd0, eStall});
    check1("done",    {31'd0, done},    {31'd0, eDone});
    check1("unit_en", {31'd0, unit_en}, {31'd0, eUnit});
    check1("busy",    {31'd0, busy},    {31'd0, eBusy});
    if (eDone) begin
      check1("rd_done",    {26'd0, rd_done}, {26'd0, eRd});
      check1("result_out", result_out, eRes);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic drv(input logic r, input logic s, input logic [1:0] o, input logic [5:0] d,
                     input logic f, input logic so, input logic [31:0] ri);
    rstn = r; start = s; op = o; rd = d; flush_e = f; stall_other = so; result_in = ri;
  endtask

  initial begin
    mInflight = 0; mHeld = 0; mAge = 0; mL = 0; mRd = '0; mHold = '0;
    drv(0, 0, 2'b00, 6'd0, 0, 0, 32'd0);
    settle();
    check1("reset_rd_done", {26'd0, rd_done}, 32'd0);
    check1("reset_result", result_out, 32'd0);
    advance();

    // FDIV: stall for nine cycles, done in the tenth, idle afterwards.
    for (int i = 0; i < 11; i++) begin
      drv(1, i < 10, 2'b01, 6'd7, 0, 0, $urandom);
      settle();
      check1("fdiv_stall", {31'd0, stall_e}, {31'd0, i < 9});
      check1("fdiv_done",  {31'd0, done},    {31'd0, i == 9});
      advance();
    end

    // FCVT completes in the launch cycle without ever stalling.
    drv(1, 1, 2'b11, 6'd5, 0, 0, 32'hCAFE_0001);
    settle();
    check1("fcvt_rd_done", {26'd0, rd_done}, 32'd5);
    check1("fcvt_busy", {31'd0, busy}, 32'd0);
    advance();
    drv(1, 0, 2'b11, 6'd0, 0, 0, $urandom);
    settle();
    advance();

    // FSQRT killed at c3, then an FMUL finishes at c5.
    for (int i = 0; i < 7; i++) begin
      drv(1, i < 6, (i < 4) ? 2'b10 : 2'b00, 6'd9, i == 3, 0, $urandom);
      settle();
      if (i == 3) check1("flush_stall", {31'd0, stall_e}, 32'd0);
      if (i == 5) check1("fmul_done", {31'd0, done}, 32'd1);
      advance();
    end

    // FMUL result held while another source stalls the pipe; start stays high.
    for (int i = 0; i < 6; i++) begin
      drv(1, i < 5, 2'b00, 6'd12, 0, (i >= 1 && i <= 3),
          (i == 1) ? 32'h3F80_0000 : $urandom);
      settle();
      if (i >= 1 && i <= 4) begin
        check1("hold_done", {31'd0, done}, 32'd1);
        check1("hold_value", result_out, 32'h3F80_0000);
      end
      if (i == 5) check1("hold_release", {31'd0, busy}, 32'd0);
      advance();
    end

    // Reset asserted in the middle of an FDIV, then a clean FMUL.
    for (int i = 0; i < 9; i++) begin
      drv(i != 4, (i < 5) || (i == 6) || (i == 7), (i < 5) ? 2'b01 : 2'b00, 6'd3, 0, 0, $urandom);
      settle();
      if (i == 4) begin
        check1("rst_stall", {31'd0, stall_e}, 32'd0);
        check1("rst_busy",  {31'd0, busy},    32'd0);
        check1("rst_unit",  {31'd0, unit_en}, 32'd0);
      end
      if (i == 6) check1("post_rst_stall", {31'd0, stall_e}, 32'd1);
      if (i == 7) check1("post_rst_done",  {31'd0, done},    32'd1);
      advance();
    end

    // Flush together with start in IDLE launches nothing.
    drv(1, 1, 2'b01, 6'd4, 1, 0, $urandom);
    settle();
    check1("fs_unit", {31'd0, unit_en}, 32'd0);
    check1("fs_stall", {31'd0, stall_e}, 32'd0);
    advance();
    drv(1, 0, 2'b01, 6'd4, 0, 0, $urandom);
    settle();
    check1("fs_busy", {31'd0, busy}, 32'd0);
    advance();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drv($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          6'($urandom_range(0, 63)), $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
          $urandom);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
